reg_output_port: RTL and testbench
==================================

// Module: reg_output_port
// PURPOSE
//  Output-side counterpart of the register write path's Input_Wire load. On an OUT
//  instruction, captures the selected architectural register into a small FIFO.
//  Presents the FIFO head on Output_Wire to an external consumer with a valid/ack
//  handshake. Sits beside the register file; the control unit stalls on OutputFull.
// PARAMETERS
//  DATA_WIDTH  32  width of registers and Output_Wire
//  FIFO_DEPTH  4   entries; power of two, >=2
//  PTR_WIDTH   2   log2(FIFO_DEPTH)
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  OutputSignal     in   1           OUT instruction strobe, 1 cycle per push
//  RegSelect        in   3           0=Acc 1=X 2=Y 3=SP 4=SR 5..7=reserved
//  Accumulator      in   DATA_WIDTH  current Acc value
//  IndexedX         in   DATA_WIDTH  current X value
//  IndexedY         in   DATA_WIDTH  current Y value
//  StackPointer     in   DATA_WIDTH  current SP value
//  StatusRegister   in   DATA_WIDTH  current SR value
//  Output_Wire      out  DATA_WIDTH  FIFO head data
//  OutputValid      out  1           Output_Wire holds an unconsumed word
//  OutputAck        in   1           consumer takes head when OutputValid=1
//  OutputFull       out  1           FIFO full; control must not strobe
//  OutputCount      out  PTR_WIDTH+1 occupied entries, 0..FIFO_DEPTH
//  OutputOverflow   out  1           sticky: push attempted while full
// BEHAVIOUR
//  Reset (async, any time): pointers=0, OutputCount=0, OutputValid=0, OutputFull=0,
//   OutputOverflow=0, Output_Wire=0. FIFO contents are don't-care. In-flight
//   handshake is abandoned; no word survives reset.
//  Push: OutputSignal=1 at edge N writes mux(RegSelect) sampled at edge N.
//   Reserved RegSelect pushes 0. Word is visible at the head after edge N,
//   i.e. OutputValid=1 in cycle N+1 when the FIFO was empty (1-cycle latency).
//  Pop: OutputValid=1 && OutputAck=1 at an edge removes the head. The next entry
//   (if any) appears on Output_Wire the following cycle. Ack with OutputValid=0
//   is ignored.
//  Output_Wire is stable while OutputValid=1 and no pop occurs. Keeps its last value
//   when the FIFO is empty.
//  Occupancy: count'=count+push-pop. OutputValid=(count!=0).
//   OutputFull=(count==FIFO_DEPTH). Both are registered/derived from count only.
//  Simultaneous push+pop:
//   - Not full: both take effect, count unchanged.
//   - Full: pop frees the slot and the push is accepted, no overflow.
//   - Empty: pop is invalid, push only.
//  Push while full without pop: data dropped, count unchanged, OutputOverflow set.
//   It stays set until reset.
//  Pointers are PTR_WIDTH bits and wrap modulo FIFO_DEPTH (3 -> 0 at default).
//  Register values are sampled, not tracked. A later change to the source register
//   does not alter queued words.
// TESTING
//  1 Reset mid-stream: 3 words queued, assert reset async between edges.
//    -> Count=0, Valid=0, Overflow=0 immediately; no old word appears after release.
//  2 Acc=0x0000_00AA, push Sel=0 at edge N, hold Ack=0.
//    -> Valid=1, Output_Wire=0xAA from N+1, stable 10 cycles. Ack then gives Valid=0.
//  3 Order and wrap: push X=1,Y=2,SP=9497,SR=5 (Full=1), pop 2, push Acc=7, 8, drain.
//    -> Consumer sees 1,2,9497,5,7,8. Pointers wrapped.
//  4 Full, push Acc=9 with no Ack.
//    -> Overflow=1, Count stays 4, 9 never output. Overflow persists after drain.
//  5 Full, push Acc=0x33 with Ack in the same cycle.
//    -> Count stays 4, Overflow=0, 0x33 emerges last.
//  6 Empty, push and Ack in the same cycle.
//    -> Count=1 next cycle, word valid. Ack with Valid=0 and RegSelect=6 push -> word 0.

Source files
------------

// File: rtl/reg_output_port.sv
// reg_output_port: captures a selected architectural register on an OUT strobe into a
// small FIFO and presents the head word to an external consumer with a valid/ack handshake.
`default_nettype none

module reg_output_port #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  OutputSignal,
  input  logic [2:0]            RegSelect,
  input  logic [DATA_WIDTH-1:0] Accumulator,
  input  logic [DATA_WIDTH-1:0] IndexedX,
  input  logic [DATA_WIDTH-1:0] IndexedY,
  input  logic [DATA_WIDTH-1:0] StackPointer,
  input  logic [DATA_WIDTH-1:0] StatusRegister,
  output logic [DATA_WIDTH-1:0] Output_Wire,
  output logic                  OutputValid,
  input  logic                  OutputAck,
  output logic                  OutputFull,
  output logic [PTR_WIDTH:0]    OutputCount,
  output logic                  OutputOverflow
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [PTR_WIDTH:0]    count;
  logic [PTR_WIDTH:0]    count_next;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head_next;
  logic                  pop;
  logic                  push_ok;

  always_comb begin
    push_data = '0;
    case (RegSelect)
      3'd0:    push_data = Accumulator;
      3'd1:    push_data = IndexedX;
      3'd2:    push_data = IndexedY;
      3'd3:    push_data = StackPointer;
      3'd4:    push_data = StatusRegister;
      default: push_data = '0;
    endcase
  end

  assign OutputValid = (count != '0);
  assign OutputFull  = (count == FULL_COUNT);
  assign OutputCount = count;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign pop        = OutputValid && OutputAck;
  assign push_ok    = OutputSignal && (!OutputFull || pop);
  assign count_next = count + (PTR_WIDTH+1)'(push_ok) - (PTR_WIDTH+1)'(pop);
  assign rd_ptr_next = pop ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;

  // The word written this edge can become the head immediately (empty, or last word popped).
  assign head_next = (push_ok && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      Output_Wire    <= '0;
      OutputOverflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next != '0) begin
        Output_Wire <= head_next;
      end
      if (OutputSignal && OutputFull && !pop) begin
        OutputOverflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_output_port.sv
// tb_reg_output_port: directed and randomized checks of reg_output_port against a queue model.
`default_nettype none

module tb_reg_output_port;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          OutputSignal;
  logic [2:0]    RegSelect;
  logic [DW-1:0] Accumulator, IndexedX, IndexedY, StackPointer, StatusRegister;
  logic [DW-1:0] Output_Wire;
  logic          OutputValid;
  logic          OutputAck;
  logic          OutputFull;
  logic [2:0]    OutputCount;
  logic          OutputOverflow;

  reg_output_port #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .OutputSignal(OutputSignal), .RegSelect(RegSelect),
    .Accumulator(Accumulator), .IndexedX(IndexedX), .IndexedY(IndexedY),
    .StackPointer(StackPointer), .StatusRegister(StatusRegister),
    .Output_Wire(Output_Wire), .OutputValid(OutputValid), .OutputAck(OutputAck),
    .OutputFull(OutputFull), .OutputCount(OutputCount), .OutputOverflow(OutputOverflow)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] seen[$];
  logic [DW-1:0] exp_out;
  bit            exp_ovf;

  function automatic logic [DW-1:0] selected();
    case (RegSelect)
      3'd0: return Accumulator;
      3'd1: return IndexedX;
      3'd2: return IndexedY;
      3'd3: return StackPointer;
      3'd4: return StatusRegister;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".wire"},  Output_Wire, exp_out);
    check({tag, ".valid"}, DW'(OutputValid), DW'(q.size() != 0));
    check({tag, ".full"},  DW'(OutputFull), DW'(q.size() == DEPTH));
    check({tag, ".count"}, DW'(OutputCount), DW'(q.size()));
    check({tag, ".ovf"},   DW'(OutputOverflow), DW'(exp_ovf));
  endtask

  task automatic model_reset();
    q.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
  endtask

  // One clock: update the model from the inputs presented at this edge, then compare.
  task automatic step(input string tag);
    logic [DW-1:0] val;
    bit            popped;
    val    = selected();
    popped = (q.size() != 0) && OutputAck;
    if (popped) seen.push_back(q.pop_front());
    if (OutputSignal) begin
      if (q.size() < DEPTH) q.push_back(val);
      else exp_ovf = 1'b1;
    end
    if (q.size() != 0) exp_out = q[0];
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic set_reg(input logic [2:0] sel, input logic [DW-1:0] val);
    RegSelect = sel;
    case (sel)
      3'd0: Accumulator    = val;
      3'd1: IndexedX       = val;
      3'd2: IndexedY       = val;
      3'd3: StackPointer   = val;
      3'd4: StatusRegister = val;
      default: ;
    endcase
  endtask

  task automatic push(input string tag, input logic [2:0] sel, input logic [DW-1:0] val);
    set_reg(sel, val);
    OutputSignal = 1'b1;
    step(tag);
    OutputSignal = 1'b0;
    Accumulator  = 32'hDEAD_0000;  // later source changes must not touch queued words
  endtask

  task automatic drain(input string tag);
    OutputAck = 1'b1;
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) step(tag);
    OutputAck = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] e3 [6];
    reset = 1'b1; OutputSignal = 1'b0; OutputAck = 1'b0; RegSelect = '0;
    Accumulator = '0; IndexedX = '0; IndexedY = '0; StackPointer = '0; StatusRegister = '0;
    model_reset();
    #2 compare_all("reset");
    #1 reset = 1'b0;
    step("idle");

    // Reset mid-stream with three words queued
    push("t1.p0", 3'd1, 32'h11); push("t1.p1", 3'd2, 32'h22); push("t1.p2", 3'd3, 32'h33);
    async_reset("t1.rst");
    repeat (3) step("t1.after");

    // Single word held without ack
    push("t2.push", 3'd0, 32'h0000_00AA);
    check("t2.head", Output_Wire, 32'hAA);
    repeat (10) step("t2.hold");
    OutputAck = 1'b1; step("t2.ack"); OutputAck = 1'b0;
    check("t2.empty", DW'(OutputValid), 32'd0);

    // Ordering and pointer wrap
    seen.delete();
    push("t3.x", 3'd1, 32'd1); push("t3.y", 3'd2, 32'd2);
    push("t3.sp", 3'd3, 32'd9497); push("t3.sr", 3'd4, 32'd5);
    check("t3.full", DW'(OutputFull), 32'd1);
    OutputAck = 1'b1; step("t3.pop0"); step("t3.pop1"); OutputAck = 1'b0;
    push("t3.a7", 3'd0, 32'd7); push("t3.a8", 3'd0, 32'd8);
    drain("t3.drain");
    e3 = '{32'd1, 32'd2, 32'd9497, 32'd5, 32'd7, 32'd8};
    check("t3.nseen", DW'(seen.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("t3.seen%0d", i), seen[i], e3[i]);

    // Push while full without ack overflows
    seen.delete();
    for (int i = 0; i < DEPTH; i++) push("t4.fill", 3'd0, DW'(32'h10 + i));
    push("t4.ovf", 3'd0, 32'd9);
    check("t4.ovfbit", DW'(OutputOverflow), 32'd1);
    check("t4.count", DW'(OutputCount), 32'd4);
    drain("t4.drain");
    check("t4.nseen", DW'(seen.size()), 32'd4);
    check("t4.last", seen[3], 32'h13);
    check("t4.sticky", DW'(OutputOverflow), 32'd1);
    async_reset("t4.rst");

    // Push while full with simultaneous ack
    seen.delete();
    for (int i = 0; i < DEPTH; i++) push("t5.fill", 3'd2, DW'(32'h20 + i));
    set_reg(3'd0, 32'h33); OutputSignal = 1'b1; OutputAck = 1'b1;
    step("t5.both");
    OutputSignal = 1'b0; OutputAck = 1'b0;
    check("t5.count", DW'(OutputCount), 32'd4);
    check("t5.ovf", DW'(OutputOverflow), 32'd0);
    drain("t5.drain");
    check("t5.last", seen[seen.size()-1], 32'h33);

    // Push with ack while empty; reserved select pushes zero
    set_reg(3'd0, 32'h66); OutputSignal = 1'b1; OutputAck = 1'b1;
    step("t6.both");
    check("t6.count", DW'(OutputCount), 32'd1);
    check("t6.word", Output_Wire, 32'h66);
    OutputAck = 1'b1; OutputSignal = 1'b0; step("t6.pop");
    Accumulator = 32'h77; IndexedX = 32'h78; RegSelect = 3'd6; OutputSignal = 1'b1;
    step("t6.rsvd");
    OutputSignal = 1'b0; OutputAck = 1'b0;
    check("t6.zero", Output_Wire, 32'd0);
    drain("t6.drain");

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 400; c++) begin
      Accumulator    = $urandom; IndexedX     = $urandom; IndexedY = $urandom;
      StackPointer   = $urandom; StatusRegister = $urandom;
      RegSelect      = 3'($urandom_range(0, 7));
      OutputSignal   = ($urandom_range(0, 99) < 55);
      OutputAck      = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 79) == 0) async_reset("rnd.rst");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
